// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared widths and FSM encoding for the register-file write arbiter
// Purpose : register-file data/address widths and the arbiter state encoding.
// Ports   : none (package regfile_pkg).
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 16;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester-side valid/ready write bus for the register-file arbiter
// Purpose : bundles the N_REQ packed write requests and their one-hot acknowledge.
// Ports   : req_valid [N_REQ], req_addr [N_REQ*ADDR_WIDTH], req_data [N_REQ*DATA_WIDTH],
//           req_ready [N_REQ]; requester i sits at slice [i*W +: W].
//           master = requester side, slave = arbiter side.
interface regfile_wr_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// rtl/regfile_wr_arbiter_rr_pick.sv - combinational round-robin priority picker
// Purpose : finds the first set bit of valid starting at ptr, wrapping modulo N_REQ
//           (N_REQ need not be a power of two).
// Ports   : valid [N_REQ] in, ptr [IDX_W] in, grant [N_REQ] one-hot out,
//           idx [IDX_W] winner index out, any out (a winner exists).
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!any && valid[IDX_W'(cand)]) begin
        any                  = 1'b1;
        grant[IDX_W'(cand)]  = 1'b1;
        idx                  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the single register-file write port
// Purpose : picks one requester per cycle and drives a registered write strobe into the
//           register file; rf_hold stalls the presented write with its fields frozen.
// Ports   : clk, rst_n (async, active low); req (regfile_wr_arbiter_if.slave);
//           rf_hold in; rf_write_en / rf_write_addr / rf_write_data out (registered);
//           grant_id out (requester whose write is on rf_write_*).
// Option  : REGFILE_ARB_R0_DISCARD_EN - grants to address 0 are acked but never strobed.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = RF_DATA_WIDTH,
  parameter  int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter  int N_REQ      = 4,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wr_arbiter_if.slave   req,
  input  logic                  rf_hold,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [IDX_W-1:0]      grant_id
);

  arb_state_t            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      ptr_next;
  logic [N_REQ-1:0]      pick_grant;
  logic                  pick_any;
  logic                  do_grant;
  logic                  win_strobe;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid (req.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A grant is only possible when the register file is taking writes this cycle; in HOLD
  // that also keeps the frozen write from being overwritten.
  assign do_grant      = rst_n && !rf_hold && pick_any;
  assign req.req_ready = do_grant ? pick_grant : '0;

  // Explicit wrap so non-power-of-two N_REQ works.
  assign ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        win_addr = req.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef REGFILE_ARB_R0_DISCARD_EN
  // Register 0 reads as zero: the request is acked but nothing reaches the register file.
  assign win_strobe = (win_addr != '0);
`else
  assign win_strobe = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      grant_id      <= '0;
    end else begin
      case (state)
        ISSUE, HOLD: begin
          if (rf_hold) begin
            // Write not taken: keep presenting it unchanged.
            state <= HOLD;
          end else if (do_grant) begin
            rr_ptr <= ptr_next;
            if (win_strobe) begin
              state         <= ISSUE;
              rf_write_en   <= 1'b1;
              rf_write_addr <= win_addr;
              rf_write_data <= win_data;
              grant_id      <= pick_idx;
            end else begin
              state       <= IDLE;
              rf_write_en <= 1'b0;
            end
          end else begin
            state       <= IDLE;
            rf_write_en <= 1'b0;
          end
        end
        IDLE: begin
          if (do_grant) begin
            rr_ptr <= ptr_next;
            if (win_strobe) begin
              state         <= ISSUE;
              rf_write_en   <= 1'b1;
              rf_write_addr <= win_addr;
              rf_write_data <= win_data;
              grant_id      <= pick_idx;
            end
          end
        end
        default: begin
          state       <= IDLE;
          rf_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
